// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM encoding and the
// Comb_OpFunct branch codes that Condition_Handler decodes.
package branch_redirect_ctrl_pkg;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HOLD     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    typedef enum logic [1:0] {
        StIdle     = S_IDLE,
        StHold     = S_HOLD,
        StRedirect = S_REDIRECT,
        StFlush    = S_FLUSH
    } state_e;

    // Comb_OpFunct = {opcode, funct3}
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [9:0] COMB_BEQ   = {OPC_BRANCH, 3'b000};
    localparam logic [9:0] COMB_BNE   = {OPC_BRANCH, 3'b001};
    localparam logic [9:0] COMB_BLT   = {OPC_BRANCH, 3'b100};
    localparam logic [9:0] COMB_BGE   = {OPC_BRANCH, 3'b101};
    localparam logic [9:0] COMB_BLTU  = {OPC_BRANCH, 3'b110};
    localparam logic [9:0] COMB_BGEU  = {OPC_BRANCH, 3'b111};

    function automatic logic is_branch_op(input logic [9:0] comb_op_funct);
        return (comb_op_funct[9:3] == OPC_BRANCH) && (comb_op_funct[2:1] != 2'b01);
    endfunction

    function automatic logic multi_hot3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer: turns EX-stage branch/jump resolutions into a
// registered PC load plus a multi-cycle IF/ID and ID/EX flush, tolerating stalls.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jal,
    input  logic              ex_is_jalr,
    input  logic              cond_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              stall_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic              illegal_combo,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  ntaken_cnt
);

    localparam int unsigned FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic              pc_load_q, pc_load_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic              illegal_q, illegal_d;
    logic              resolve, taken_inc, ntaken_inc;

    always_comb begin
        resolve    = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond_taken));
        state_d    = state_q;
        target_d   = target_q;
        fcnt_d     = fcnt_q;
        illegal_d  = illegal_q;
        ntaken_inc = 1'b0;

        unique case (state_q)
            StIdle: begin
                illegal_d = illegal_q |
                            (ex_valid & multi_hot3(ex_is_branch, ex_is_jal, ex_is_jalr));
                if (resolve) begin
                    target_d = ex_target;
                    state_d  = stall_in ? StHold : StRedirect;
                end else if (ex_valid && ex_is_branch && !stall_in) begin
                    ntaken_inc = 1'b1;
                end
            end
            StHold: begin
                if (!stall_in) state_d = StRedirect;
            end
            StRedirect: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = StFlush;
                    fcnt_d  = FCW'(FLUSH_CYCLES - 2);
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (fcnt_q == '0) state_d = StIdle;
                else              fcnt_d  = fcnt_q - FCW'(1);
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so pc_load lands one cycle
        // after the resolving EX cycle.
        taken_inc     = (state_d == StRedirect);
        pc_load_d     = taken_inc;
        redirect_pc_d = taken_inc ? target_d : redirect_pc_q;
        flush_d       = (state_d == StRedirect) || (state_d == StFlush);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            target_q      <= '0;
            redirect_pc_q <= '0;
            fcnt_q        <= '0;
            pc_load_q     <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            redirect_pc_q <= redirect_pc_d;
            fcnt_q        <= fcnt_d;
            pc_load_q     <= pc_load_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (taken_inc),
        .clr   (1'b0),
        .count (taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ntaken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ntaken_inc),
        .clr   (1'b0),
        .count (ntaken_cnt)
    );

    assign pc_load       = pc_load_q;
    assign redirect_pc   = redirect_pc_q;
    assign flush_if_id   = flush_q;
    assign flush_id_ex   = flush_q;
    assign busy          = busy_q;
    assign illegal_combo = illegal_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scenario bench for branch_redirect_ctrl: default instance plus a 4-bit counter
// instance sharing the same stimulus for saturation.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cond_taken, stall_in;
    logic [31:0] ex_target;

    logic        pc_load, flush_if_id, flush_id_ex, busy, illegal_combo;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt, ntaken_cnt;

    logic        s_pc_load, s_flush_if_id, s_flush_id_ex, s_busy, s_illegal_combo;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_taken_cnt, s_ntaken_cnt;

    always #5 clk = ~clk;

    branch_redirect_ctrl dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .cond_taken(cond_taken),
        .ex_target(ex_target), .stall_in(stall_in), .pc_load(pc_load),
        .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .busy(busy), .illegal_combo(illegal_combo), .taken_cnt(taken_cnt),
        .ntaken_cnt(ntaken_cnt)
    );

    branch_redirect_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .cond_taken(cond_taken),
        .ex_target(ex_target), .stall_in(stall_in), .pc_load(s_pc_load),
        .redirect_pc(s_redirect_pc), .flush_if_id(s_flush_if_id),
        .flush_id_ex(s_flush_id_ex), .busy(s_busy), .illegal_combo(s_illegal_combo),
        .taken_cnt(s_taken_cnt), .ntaken_cnt(s_ntaken_cnt)
    );

    typedef struct packed {
        logic rst, v, br, jal, jalr, cond, stall;
        logic [31:0] tgt;
    } stim_t;

    typedef struct packed {
        logic        pc_load;
        logic [31:0] rpc;
        logic        fl_if;
        logic        fl_ex;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic stim_t st(input logic rst, input logic v, input logic br,
                                 input logic jal, input logic jalr, input logic cond,
                                 input logic stall, input logic [31:0] tgt);
        stim_t s;
        s = '{rst: rst, v: v, br: br, jal: jal, jalr: jalr, cond: cond, stall: stall, tgt: tgt};
        return s;
    endfunction

    function automatic exp_t ex(input logic pc, input logic [31:0] rpc, input logic fl,
                                input logic bsy);
        exp_t e;
        e = '{pc_load: pc, rpc: rpc, fl_if: fl, fl_ex: fl, busy: bsy};
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o = '{pc_load: pc_load, rpc: redirect_pc, fl_if: flush_if_id, fl_ex: flush_id_ex,
              busy: busy};
        return o;
    endfunction

    task automatic drive(input stim_t s);
        reset        = s.rst;
        ex_valid     = s.v;
        ex_is_branch = s.br;
        ex_is_jal    = s.jal;
        ex_is_jalr   = s.jalr;
        cond_taken   = s.cond;
        stall_in     = s.stall;
        ex_target    = s.tgt;
    endtask

    task automatic test_reset();
        exp_t got, want;
        drive(st(1, 1, 0, 1, 0, 0, 0, 32'hDEAD));
        sb.push_back(ex(0, 0, 0, 0));
        @(posedge clk); #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++; $display("FAIL reset_outputs got=%h want=%h", got, want);
        end
        n_cmp++;
        if ({taken_cnt, ntaken_cnt, illegal_combo, s_taken_cnt} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_counters got=%h/%h/%b/%h want=0", taken_cnt, ntaken_cnt,
                     illegal_combo, s_taken_cnt);
        end
    endtask

    task automatic test_beq_taken();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,1,0,0,1,0,32'h100), st(0,0,0,0,0,0,0,0),
              st(0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(1,32'h100,1,1), ex(0,32'h100,1,1), ex(0,32'h100,0,0),
              ex(0,32'h100,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL beq_taken cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (taken_cnt !== 16'd1 || ntaken_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL beq_taken_cnt got=%0d/%0d want=1/0", taken_cnt, ntaken_cnt);
        end
    endtask

    task automatic test_bne_not_taken();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        // Fourth branch is stalled so it must not count.
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,1,0,0,0,0,32'h44), st(0,1,1,0,0,0,0,32'h48),
              st(0,1,1,0,0,0,0,32'h4C), st(0,1,1,0,0,0,1,32'h50), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(0,0,0,0), ex(0,0,0,0), ex(0,0,0,0), ex(0,0,0,0), ex(0,0,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL bne_ntaken cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (ntaken_cnt !== 16'd3 || taken_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL bne_ntaken_cnt got=%0d/%0d want=3/0", ntaken_cnt, taken_cnt);
        end
    endtask

    task automatic test_jal_stall();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,0,1,0,0,1,32'h200), st(0,1,0,0,1,0,1,32'h999),
              st(0,1,0,0,1,0,1,32'h999), st(0,1,1,0,0,0,1,32'h999), st(0,0,0,0,0,0,0,0),
              st(0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(0,0,0,1), ex(0,0,0,1), ex(0,0,0,1), ex(0,0,0,1),
              ex(1,32'h200,1,1), ex(0,32'h200,1,1), ex(0,32'h200,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL jal_stall cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (taken_cnt !== 16'd1 || ntaken_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL jal_stall_cnt got=%0d/%0d want=1/0", taken_cnt, ntaken_cnt);
        end
    endtask

    task automatic test_wrong_path();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,1,0,0,1,0,32'h180), st(0,1,0,0,1,0,1,32'h300),
              st(0,1,0,0,1,0,0,32'h300), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(1,32'h180,1,1), ex(0,32'h180,1,1), ex(0,32'h180,0,0),
              ex(0,32'h180,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL wrong_path cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (taken_cnt !== 16'd1) begin
            n_fail++; $display("FAIL wrong_path_cnt got=%0d want=1", taken_cnt);
        end
    endtask

    task automatic test_reset_in_flush();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,0,1,1,0,0,32'h500), st(0,0,0,0,0,0,0,0),
              st(1,1,0,1,0,0,0,32'h777), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(1,32'h500,1,1), ex(0,32'h500,1,1), ex(0,0,0,0), ex(0,0,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL reset_flush cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (taken_cnt !== 16'd0 || ntaken_cnt !== 16'd0 || illegal_combo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_state got=%0d/%0d/%b want=0/0/0", taken_cnt,
                     ntaken_cnt, illegal_combo);
        end
    endtask

    task automatic test_illegal_and_saturation();
        stim_t s[$]; exp_t e[$]; exp_t got, want;
        int cq[$];
        int want_cnt;
        s = '{st(1,0,0,0,0,0,0,0), st(0,1,1,1,0,0,0,32'h600), st(0,0,0,0,0,0,0,0),
              st(0,0,0,0,0,0,0,0), st(0,0,0,0,0,0,0,0)};
        e = '{ex(0,0,0,0), ex(1,32'h600,1,1), ex(0,32'h600,1,1), ex(0,32'h600,0,0),
              ex(0,32'h600,0,0)};
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want);
            end
        end
        n_cmp++;
        if (illegal_combo !== 1'b1 || taken_cnt !== 16'd1 || ntaken_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL illegal_flag got=%b/%0d/%0d want=1/1/0", illegal_combo, taken_cnt,
                     ntaken_cnt);
        end
        // 16 more jumps, each spaced to land in IDLE.
        for (int k = 0; k < 16; k++) begin
            drive(st(0, 1, 0, 1, 0, 0, 0, 32'h1000 + 32'(k)));
            cq.push_back((k + 2 > 15) ? 15 : k + 2);
            @(posedge clk); #1;
            drive(st(0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            @(posedge clk); #1;
            want_cnt = cq.pop_front(); n_cmp++;
            if (s_taken_cnt !== 4'(want_cnt)) begin
                n_fail++;
                $display("FAIL sat_cnt iter%0d got=%0d want=%0d", k, s_taken_cnt, want_cnt);
            end
        end
        n_cmp++;
        if (taken_cnt !== 16'd17 || illegal_combo !== 1'b1 || s_illegal_combo !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final got=%0d/%b/%b want=17/1/1", taken_cnt, illegal_combo,
                     s_illegal_combo);
        end
    endtask

    initial begin
        drive(st(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_jal_stall();
        test_wrong_path();
        test_reset_in_flush();
        test_illegal_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
